// File: rtl/note_sequencer.sv
// note_sequencer: steps through a programmable table of just-intonation notes and
// drives the synthesizer with a Q.20 frequency word, filter cutoff and gate.
module note_sequencer #(
    parameter int          DEPTH           = 16,
    parameter int          HALF_BEAT_TICKS = 24000,
    parameter logic [31:0] BASE_FREQ_Q20   = 32'd115343360,
    localparam int         AW              = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sample_tick,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [16:0]   wr_data,
    output logic [31:0]   frequency,
    output logic [2:0]    cutoff,
    output logic          gate,
    output logic [AW-1:0] step,
    output logic          note_strobe,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CALC,
        PLAY,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [16:0]   table_mem [DEPTH];
    logic [16:0]   rd_data;
    logic [AW-1:0] addr;
    logic [23:0]   remaining;

    logic [7:0]    entry_len;
    logic [2:0]    entry_cut;
    logic [1:0]    entry_oct;
    logic [3:0]    entry_note;
    logic          entry_pitched;
    logic [21:0]   ratio;
    logic [31:0]   note_base;
    logic [31:0]   note_freq;
    logic          last_tick;
    logic          at_last_entry;

    // Ratio values are floor(num * 2^20 / den); indices 13..15 are rests.
    function automatic logic [21:0] ratio_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    ratio_rom = 22'd1048576;
            4'd1:    ratio_rom = 22'd1118481;
            4'd2:    ratio_rom = 22'd1179648;
            4'd3:    ratio_rom = 22'd1258291;
            4'd4:    ratio_rom = 22'd1310720;
            4'd5:    ratio_rom = 22'd1398101;
            4'd6:    ratio_rom = 22'd1474560;
            4'd7:    ratio_rom = 22'd1572864;
            4'd8:    ratio_rom = 22'd1677721;
            4'd9:    ratio_rom = 22'd1747626;
            4'd10:   ratio_rom = 22'd1864135;
            4'd11:   ratio_rom = 22'd1966080;
            4'd12:   ratio_rom = 22'd2097152;
            default: ratio_rom = 22'd0;
        endcase
    endfunction

    assign entry_len     = rd_data[16:9];
    assign entry_cut     = rd_data[8:6];
    assign entry_oct     = rd_data[5:4];
    assign entry_note    = rd_data[3:0];
    assign entry_pitched = (entry_note <= 4'd12);

    always_comb begin
        ratio     = ratio_rom(entry_note);
        note_base = 32'((64'(BASE_FREQ_Q20) * 64'(ratio)) >> 20);
        note_freq = note_base << entry_oct;
    end

    assign last_tick     = (state == PLAY) && sample_tick && (remaining == 24'd1);
    assign at_last_entry = (addr == AW'(DEPTH - 1));

    // Table RAM has no reset; a same-cycle write to the read address returns old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_mem[wr_addr] <= wr_data;
        end
        if (state == FETCH) begin
            rd_data <= table_mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = FETCH;
                end
            end
            FETCH: next_state = CALC;
            CALC: begin
                // A zero-length first entry with looping would spin forever, so it ends instead.
                if (entry_len == 8'd0) begin
                    next_state = (loop_en && (addr != '0)) ? FETCH : DONE;
                end else begin
                    next_state = PLAY;
                end
            end
            PLAY: begin
                if (last_tick) begin
                    next_state = (at_last_entry && !loop_en) ? DONE : FETCH;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (stop) begin
            next_state = IDLE;
        end
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Outputs hold through FETCH/CALC between notes so the gate never drops mid-pattern.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr        <= '0;
            remaining   <= '0;
            frequency   <= '0;
            cutoff      <= '0;
            gate        <= 1'b0;
            step        <= '0;
            note_strobe <= 1'b0;
        end else begin
            note_strobe <= 1'b0;
            if (stop) begin
                frequency <= '0;
                cutoff    <= '0;
                gate      <= 1'b0;
                step      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            addr <= '0;
                        end
                    end
                    CALC: begin
                        if (next_state == PLAY) begin
                            frequency   <= entry_pitched ? note_freq : 32'd0;
                            cutoff      <= entry_cut;
                            gate        <= entry_pitched;
                            step        <= addr;
                            note_strobe <= 1'b1;
                            remaining   <= 24'(entry_len) * 24'(HALF_BEAT_TICKS);
                        end else if (next_state == FETCH) begin
                            addr <= '0;
                        end
                    end
                    PLAY: begin
                        if (sample_tick) begin
                            if (remaining == 24'd1) begin
                                addr <= addr + AW'(1);
                            end else begin
                                remaining <= remaining - 24'd1;
                            end
                        end
                    end
                    default: ;
                endcase
                if (next_state == DONE) begin
                    frequency <= '0;
                    cutoff    <= '0;
                    gate      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed and randomized playback checked every cycle against a
// note-timeline reference model (durations in ticks, fixed 3-cycle note latency).
module tb_note_sequencer;

    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam int          HBT   = 4;
    localparam logic [31:0] BASE  = 32'd115343360;
    localparam int          NUM [13] = '{1, 16, 9, 6, 5, 4, 45, 3, 8, 5, 16, 15, 2};
    localparam int          DEN [13] = '{1, 15, 8, 5, 4, 3, 32, 2, 5, 3, 9, 8, 1};

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sample_tick;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [16:0]   wr_data;
    logic [31:0]   frequency;
    logic [2:0]    cutoff;
    logic          gate;
    logic [AW-1:0] step;
    logic          note_strobe;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tick_period = 1;

    logic [16:0] tbl [DEPTH];

    int          m_wait;
    int          m_ticks;
    int          m_idx;
    bit          m_busy;
    bit          m_done;
    bit          m_strobe;
    bit          m_playing;
    bit          m_gate;
    logic [31:0] m_freq;
    logic [2:0]  m_cut;
    logic [3:0]  m_step;

    note_sequencer #(
        .DEPTH(DEPTH),
        .HALF_BEAT_TICKS(HBT),
        .BASE_FREQ_Q20(BASE)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sample_tick(sample_tick),
        .start(start),
        .stop(stop),
        .loop_en(loop_en),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .frequency(frequency),
        .cutoff(cutoff),
        .gate(gate),
        .step(step),
        .note_strobe(note_strobe),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_freq(input int note, input int oct);
        longint ratio;
        longint prod;
        ratio = (longint'(NUM[note]) << 20) / longint'(DEN[note]);
        prod  = longint'(BASE) * ratio;
        return 32'((prod >> 20) << oct);
    endfunction

    function automatic void fire_done();
        m_done = 1;
        m_gate = 0;
        m_freq = '0;
        m_cut  = '0;
    endfunction

    function automatic void fetch_event();
        int len;
        int note;
        len  = int'(tbl[m_idx][16:9]);
        note = int'(tbl[m_idx][3:0]);
        if (len == 0) begin
            if (loop_en && m_idx != 0) begin
                m_idx  = 0;
                m_wait = 2;
            end else begin
                fire_done();
            end
        end else begin
            m_strobe  = 1;
            m_playing = 1;
            m_ticks   = len * HBT;
            m_step    = 4'(m_idx);
            m_cut     = tbl[m_idx][8:6];
            m_gate    = (note <= 12);
            m_freq    = (note <= 12) ? model_freq(note, int'(tbl[m_idx][5:4])) : 32'd0;
        end
    endfunction

    function automatic void note_finished();
        if (m_idx == DEPTH - 1 && !loop_en) begin
            fire_done();
        end else begin
            m_idx  = (m_idx + 1) % DEPTH;
            m_wait = 2;
        end
    endfunction

    function automatic void model_edge(input logic st, input logic sp, input logic tk, input logic rn);
        m_strobe = 0;
        if (!rn || sp) begin
            m_busy    = 0;
            m_done    = 0;
            m_playing = 0;
            m_wait    = 0;
            m_ticks   = 0;
            m_freq    = '0;
            m_cut     = '0;
            m_gate    = 0;
            m_step    = '0;
        end else if (!m_busy) begin
            if (st) begin
                m_busy = 1;
                m_idx  = 0;
                m_wait = 2;
            end
        end else if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (m_playing) begin
            if (tk) begin
                m_ticks--;
                if (m_ticks == 0) begin
                    m_playing = 0;
                    note_finished();
                end
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                fetch_event();
            end
        end
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_all();
        check_output("frequency", frequency, m_freq);
        check_output("cutoff", 32'(cutoff), 32'(m_cut));
        check_output("gate", 32'(gate), 32'(m_gate));
        check_output("step", 32'(step), 32'(m_step));
        check_output("note_strobe", 32'(note_strobe), 32'(m_strobe));
        check_output("busy", 32'(busy), 32'(m_busy));
        check_output("done", 32'(done), 32'(m_done));
    endtask

    task automatic apply_stimulus(input logic st, input logic sp, input logic we,
                                  input logic [AW-1:0] wa, input logic [16:0] wd);
        logic tk;
        if (tick_period == 0) tk = 1'($urandom_range(0, 1));
        else                  tk = ((cyc % tick_period) == 0);
        start       = st;
        stop        = sp;
        wr_en       = we;
        wr_addr     = wa;
        wr_data     = wd;
        sample_tick = tk;
        @(posedge clk);
        model_edge(st, sp, tk, reset_n);
        if (we) tbl[wa] = wd;
        cyc++;
        #1;
        check_all();
    endtask

    task automatic idle_cycle();
        apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic write_entry(input int addr, input int len, input int cut, input int oct, input int note);
        apply_stimulus(1'b0, 1'b0, 1'b1, AW'(addr), {8'(len), 3'(cut), 2'(oct), 4'(note)});
    endtask

    task automatic wait_for_strobe(input int limit, output int n);
        n = 0;
        do begin
            idle_cycle();
            n++;
        end while (note_strobe !== 1'b1 && n < limit);
        check_output("strobe_seen", 32'(note_strobe), 32'd1);
    endtask

    task automatic wait_for_done(input int limit, output int n);
        n = 0;
        do begin
            idle_cycle();
            n++;
        end while (done !== 1'b1 && n < limit);
        check_output("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        int n;
        int k;
        reset_n = 1'b0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; sample_tick = 1'b0;
        model_edge(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) idle_cycle();
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) write_entry(i, 0, 0, 0, 0);

        $display("[TB] basic note");
        write_entry(0, 1, 1, 0, 0);
        write_entry(1, 0, 0, 0, 0);
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
        wait_for_strobe(8, n);
        check_output("start_latency", 32'(n), 32'd2);
        check_output("basic_freq", frequency, 32'd115343360);
        check_output("basic_cutoff", 32'(cutoff), 32'd1);
        check_output("basic_gate", 32'(gate), 32'd1);
        wait_for_done(40, n);
        check_output("basic_done_delay", 32'(n), 32'd6);
        check_output("done_freq", frequency, 32'd0);
        check_output("done_gate", 32'(gate), 32'd0);
        idle_cycle();
        check_output("idle_busy", 32'(busy), 32'd0);

        $display("[TB] ratio arithmetic");
        write_entry(0, 1, 2, 0, 7);
        write_entry(1, 1, 3, 0, 5);
        write_entry(2, 1, 4, 1, 12);
        write_entry(3, 0, 0, 0, 0);
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
        wait_for_strobe(8, n);
        check_output("ratio7", frequency, 32'd173015040);
        check_output("ratio7_step", 32'(step), 32'd0);
        wait_for_strobe(12, n);
        check_output("ratio5", frequency, 32'd153791110);
        check_output("ratio5_step", 32'(step), 32'd1);
        wait_for_strobe(12, n);
        check_output("ratio12_oct1", frequency, 32'd461373440);
        check_output("ratio12_step", 32'(step), 32'd2);
        wait_for_done(20, n);
        idle_cycle();

        $display("[TB] rest");
        write_entry(0, 2, 5, 0, 13);
        write_entry(1, 1, 2, 0, 0);
        write_entry(2, 0, 0, 0, 0);
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
        wait_for_strobe(8, n);
        check_output("rest_gate", 32'(gate), 32'd0);
        check_output("rest_freq", frequency, 32'd0);
        wait_for_strobe(20, n);
        check_output("rest_duration", 32'(n), 32'd10);
        check_output("after_rest_freq", frequency, 32'd115343360);
        wait_for_done(20, n);
        idle_cycle();

        $display("[TB] loop, end of table and stop");
        for (int i = 0; i < DEPTH; i++) write_entry(i, 1, i % 8, i % 4, i % 13);
        loop_en = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
        for (k = 0; k < 18; k++) begin
            wait_for_strobe(12, n);
            check_output("loop_step", 32'(step), 32'(k % DEPTH));
        end
        apply_stimulus(1'b1, 1'b1, 1'b0, '0, '0);
        check_output("stop_busy", 32'(busy), 32'd0);
        check_output("stop_freq", frequency, 32'd0);
        check_output("stop_step", 32'(step), 32'd0);
        loop_en = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
        wait_for_done(200, n);
        idle_cycle();
        write_entry(0, 0, 0, 0, 0);
        loop_en = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
        wait_for_done(10, n);
        check_output("zero_len_first_done", 32'(n), 32'd2);
        idle_cycle();
        loop_en = 1'b0;

        $display("[TB] tick gaps and ignored start");
        tick_period = 3;
        write_entry(0, 1, 6, 2, 3);
        write_entry(1, 0, 0, 0, 0);
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
        wait_for_strobe(8, n);
        repeat (2) idle_cycle();
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
        check_output("midplay_start_freq", frequency, model_freq(3, 2));
        check_output("midplay_start_step", 32'(step), 32'd0);
        wait_for_done(40, n);
        idle_cycle();
        tick_period = 1;

        $display("[TB] reset mid-play");
        write_entry(0, 2, 3, 1, 4);
        write_entry(1, 0, 0, 0, 0);
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
        wait_for_strobe(8, n);
        repeat (2) idle_cycle();
        reset_n = 1'b0;
        idle_cycle();
        reset_n = 1'b1;
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_gate", 32'(gate), 32'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
        wait_for_strobe(8, n);
        check_output("replay_freq", frequency, model_freq(4, 1));
        check_output("replay_cutoff", 32'(cutoff), 32'd3);
        wait_for_done(30, n);
        idle_cycle();

        $display("[TB] randomized patterns");
        tick_period = 0;
        for (int r = 0; r < 4; r++) begin
            int cnt;
            cnt = int'($urandom_range(3, 8));
            for (int i = 0; i < cnt; i++) begin
                write_entry(i, int'($urandom_range(1, 3)), int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            end
            write_entry(cnt, 0, 0, 0, 0);
            loop_en = (r == 3);
            apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
            if (r == 3) begin
                repeat (120) idle_cycle();
                apply_stimulus(1'b0, 1'b1, 1'b0, '0, '0);
                check_output("rand_stop_busy", 32'(busy), 32'd0);
            end else begin
                wait_for_done(400, n);
            end
            idle_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Hardware pattern player that drives the synthesizer's frequency and cutoff inputs.
- Plays a programmable table of notes: each entry is a just-intonation ratio index, an octave, a filter cutoff and a duration.
- For each entry it computes a Q.20 frequency word and holds it for a counted number of sample ticks, then advances to the next entry.
- Sits between the control/register logic (which writes the table) and the synthesizer core.

Parameters:
- DEPTH, 16: pattern entries; power of two; AW = log2(DEPTH).
- HALF_BEAT_TICKS, 24000: sample ticks per length unit.
- BASE_FREQ_Q20, 115343360: root frequency (110 Hz) in unsigned Q.20.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- sample_tick  in  1  one-cycle pulse per audio sample
- start  in  1  pulse; begin playback at entry 0
- stop  in  1  pulse; abort playback
- loop_en  in  1  wrap to entry 0 at pattern end instead of finishing
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table write address
- wr_data  in  17  [16:9] length, [8:6] cutoff, [5:4] octave, [3:0] note
- frequency  out  32  Q.20 frequency word to synthesizer
- cutoff  out  3  filter cutoff to synthesizer
- gate  out  1  high while a pitched note plays
- step  out  AW  index of the entry currently playing
- note_strobe  out  1  one-cycle pulse when new frequency/cutoff become valid
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at non-looping pattern end

Behaviour:
- Reset (reset_n low at a clk edge): all outputs 0, state IDLE, address 0. Table contents are not reset. Reset mid-play aborts immediately.
- Table: DEPTH x 17 synchronous RAM, written on wr_en at any time.
  - Reads are registered.
  - A write to the address being read in the same cycle returns old data.
  - Writes during play take effect when that entry is next fetched.
- Ratio ROM, indices 0..12: 1/1, 16/15, 9/8, 6/5, 5/4, 4/3, 45/32, 3/2, 8/5, 5/3, 16/9, 15/8, 2/1.
  - Each ROM value is floor(num * 2^20 / den).
  - Notes 13..15 are rests.
- Frequency = ((BASE_FREQ_Q20 * ratio) >> 20) << octave.
  - The product is computed at 64 bits and truncated to 32; no rounding.
- FSM states:
  - IDLE: start (with stop low) -> FETCH with addr = 0. start while busy is ignored.
  - FETCH: issue read of addr -> CALC.
  - CALC: register the entry. Then:
    - If length == 0, or addr wrapped past DEPTH-1 while looping: end-of-pattern handling (below).
    - Otherwise compute frequency, load remaining = length * HALF_BEAT_TICKS (24-bit counter) -> PLAY.
  - PLAY, on entry:
    - frequency, cutoff and step update, and note_strobe pulses.
    - gate = 1 for notes 0..12. For rests, gate = 0 and frequency = 0, but the duration still counts.
    - On each sample_tick, remaining decrements.
    - A tick with remaining == 1 -> FETCH with addr + 1.
    - If addr was DEPTH-1, the pattern ends: wrap to 0 if loop_en, else DONE.
  - End of pattern (length == 0 entry, or past the last entry):
    - If loop_en: FETCH at addr 0. A length == 0 entry at address 0 with loop_en goes to DONE to avoid a spin.
    - Otherwise: DONE.
  - DONE: done pulses for 1 cycle; gate, frequency and cutoff clear to 0 -> IDLE.
- Latency: start sampled at edge t gives FETCH at t+1, CALC at t+2, and outputs valid with note_strobe at t+3.
  - Between notes, the previous outputs hold through FETCH/CALC (2 cycles); there is no gate gap.
  - The next note becomes valid 3 cycles after the final tick.
- stop: from any state, enter IDLE at the next edge; gate, frequency, cutoff and step clear; no done pulse. stop wins over a simultaneous start.
- sample_tick is ignored outside PLAY. Ticks arriving during FETCH/CALC are not counted.
- loop_en is sampled only at pattern end.

Test Plan:
Bench uses HALF_BEAT_TICKS = 4.
- Basic note: entry0 = {len 1, cut 1, oct 0, note 0}, entry1 len 0; start, tick every cycle -> at t+3 frequency 115343360, cutoff 1, gate 1, note_strobe; held 4 ticks; then done pulse, all outputs 0, busy 0.
- Ratio arithmetic: note 7 oct 0 -> 173015040; note 5 -> 153791110 (ratio 1398101, floor); note 12 oct 1 -> 461373440; consecutive entries with no gate gap, step 0,1,2.
- Rest: note 13, len 2 -> gate 0, frequency 0 for 8 ticks, then next entry plays normally.
- Loop and stop: 16 entries all len 1, loop_en 1 -> after step 15, step returns to 0 with no done; pulse stop+start together -> IDLE next cycle, outputs 0, busy 0.
- Tick gaps and ignored start: sample_tick every 3rd cycle with len 1 -> note held 12 cycles; a start pulse mid-play changes nothing.
- Reset mid-play: assert reset_n low during PLAY -> next edge all outputs 0, IDLE. Table retained: a new start replays entry0.
